golden_nonce_queue: RTL

GOLDEN_NONCE_QUEUE -- requirements
Module: golden_nonce_queue

---
 rtl/golden_nonce_queue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/golden_nonce_queue.sv
// Golden-nonce buffer between the hashing control unit and the serial transmitter.
// Queues accepted nonces, drops duplicates and overflow, and hands them out one at a time.
module golden_nonce_queue #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  hash_clk,
    input  logic                  reset_in,
    input  logic                  nonce_valid,
    input  logic [31:0]           nonce_in,
    input  logic                  tx_busy,
    output logic                  tx_send,
    output logic [31:0]           tx_word,
    output logic [DEPTH_LOG2:0]   level,
    output logic [7:0]            drop_cnt,
    output logic [1:0]            fsm_state
);

    localparam int                DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE   = (DEPTH_LOG2 + 1)'(1);

    // Transmitter handshake: tx_send is a one-cycle request carrying tx_word; the
    // transmitter acknowledges by raising tx_busy, and the entry is released only
    // once tx_busy has fallen again. No acknowledge within 16 cycles means re-send.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_IDLE = 2'd3
    } state_t;

    state_t                  state;
    logic [31:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [31:0]             last_nonce;
    logic                    last_valid;
    logic [3:0]              retry_cnt;

    logic full;
    logic dup;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        full = (level == FULL);
        pop  = (state == WAIT_IDLE) && !tx_busy;
        dup  = nonce_valid && last_valid && (nonce_in == last_nonce);
        // A pop in the same cycle frees the slot, so a full queue can still accept.
        push = nonce_valid && !dup && (!full || pop);
        drop = nonce_valid && !dup && full && !pop;
    end

    assign fsm_state = state;

    always_ff @(posedge hash_clk) begin
        if (push) begin
            mem[wr_ptr] <= nonce_in;
        end
    end

    always_ff @(posedge hash_clk or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            drop_cnt   <= '0;
            last_nonce <= '0;
            last_valid <= 1'b0;
        end else begin
            // The newest accepted nonce stays "live" until the queue empties.
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_nonce <= nonce_in;
                last_valid <= 1'b1;
            end else if (pop && level == ONE) begin
                last_valid <= 1'b0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + ONE;
                2'b01:   level <= level - ONE;
                default: level <= level;
            endcase
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge hash_clk or negedge reset_in) begin
        if (!reset_in) begin
            state     <= IDLE;
            tx_send   <= 1'b0;
            tx_word   <= '0;
            retry_cnt <= '0;
        end else begin
            tx_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (level != '0 && !tx_busy) begin
                        state   <= REQ;
                        tx_send <= 1'b1;
                        tx_word <= mem[rd_ptr];
                    end
                end
                REQ: begin
                    state     <= WAIT_BUSY;
                    retry_cnt <= '0;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_IDLE;
                    end else if (retry_cnt == 4'd15) begin
                        // tx_word still holds the head entry, so the retry re-sends it.
                        state   <= REQ;
                        tx_send <= 1'b1;
                    end else begin
                        retry_cnt <= retry_cnt + 4'd1;
                    end
                end
                WAIT_IDLE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
